// File: rtl/tcdm_initiator_shim.sv
// tcdm_initiator_shim: per-initiator front end for one TCDM interconnect port.
// Turns a core valid/ready request stream into req/gnt handshakes, buffers requests
// and responses, and only issues a request when the response FIFO is sure to have
// room for its reply, because vld/rdata from the interconnect cannot be stalled.
// Optional macro TCDM_SHIM_PERF_EN adds a saturating 32-bit grant-stall counter
// on perf_stall_o; without it the output is tied to zero and no counter exists.
module tcdm_initiator_shim #(
    parameter int AddrWidth   = 32,
    parameter int DataWidth   = 32,
    parameter int BeWidth     = DataWidth / 8,
    parameter int ReqDepth    = 2,
    parameter int RespDepth   = 4,
    parameter int WriteRespOn = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 core_req_valid_i,
    output logic                 core_req_ready_o,
    input  logic [AddrWidth-1:0] core_add_i,
    input  logic                 core_wen_i,
    input  logic [DataWidth-1:0] core_wdata_i,
    input  logic [BeWidth-1:0]   core_be_i,
    output logic                 core_rsp_valid_o,
    input  logic                 core_rsp_ready_i,
    output logic [DataWidth-1:0] core_rsp_rdata_o,
    output logic                 tcdm_req_o,
    input  logic                 tcdm_gnt_i,
    output logic [AddrWidth-1:0] tcdm_add_o,
    output logic                 tcdm_wen_o,
    output logic [DataWidth-1:0] tcdm_wdata_o,
    output logic [BeWidth-1:0]   tcdm_be_o,
    input  logic                 tcdm_vld_i,
    input  logic [DataWidth-1:0] tcdm_rdata_i,
    output logic                 err_o,
    output logic [31:0]          perf_stall_o
);
    localparam int CntW    = $clog2(RespDepth + 1);
    localparam int ReqCntW = $clog2(ReqDepth + 1);
    localparam int ReqPtrW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
    localparam int RspPtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int EntW    = AddrWidth + 1 + DataWidth + BeWidth;
    localparam logic WrResp = (WriteRespOn != 0);

    // Request FIFO state
    logic [EntW-1:0]    req_mem [ReqDepth];
    logic [ReqPtrW-1:0] req_wptr_reg, req_rptr_reg;
    logic [ReqCntW-1:0] req_count_reg;
    // Response FIFO state
    logic [DataWidth-1:0] rsp_mem [RespDepth];
    logic [RspPtrW-1:0]   rsp_wptr_reg, rsp_rptr_reg;
    logic [CntW-1:0]      rsp_count_reg;
    logic [CntW-1:0]      inflight_reg;
    logic                 err_reg;

    logic                 req_empty, req_full, req_push, grant, need;
    logic                 rsp_empty, rsp_push, rsp_pop, spurious;
    logic [AddrWidth-1:0] head_add;
    logic                 head_wen;
    logic [DataWidth-1:0] head_wdata;
    logic [BeWidth-1:0]   head_be;
    logic [CntW:0]        credit_sum;

    assign req_empty = (req_count_reg == '0);
    assign req_full  = (req_count_reg == ReqCntW'(ReqDepth));
    assign rsp_empty = (rsp_count_reg == '0);

    assign {head_add, head_wen, head_wdata, head_be} = req_mem[req_rptr_reg];

    // Stores only consume a response slot when the interconnect acknowledges them.
    assign need       = !req_empty && (!head_wen || WrResp);
    assign credit_sum = {1'b0, inflight_reg} + {1'b0, rsp_count_reg} + (CntW + 1)'(need);

    assign core_req_ready_o = !req_full;
    assign req_push         = core_req_valid_i && !req_full;
    assign tcdm_req_o       = !req_empty && (credit_sum <= (CntW + 1)'(RespDepth));
    assign grant            = tcdm_req_o && tcdm_gnt_i;

    // Outputs read as zero while nothing is buffered, so reset leaves them clean.
    assign tcdm_add_o   = req_empty ? '0 : head_add;
    assign tcdm_wen_o   = req_empty ? 1'b0 : head_wen;
    assign tcdm_wdata_o = req_empty ? '0 : head_wdata;
    assign tcdm_be_o    = req_empty ? '0 : head_be;

    // A vld with nothing outstanding is a protocol violation and is dropped.
    assign spurious = tcdm_vld_i && (inflight_reg == '0);
    assign rsp_push = tcdm_vld_i && (inflight_reg != '0);
    assign rsp_pop  = !rsp_empty && core_rsp_ready_i;

    assign core_rsp_valid_o = !rsp_empty;
    assign core_rsp_rdata_o = rsp_empty ? '0 : rsp_mem[rsp_rptr_reg];
    assign err_o            = err_reg;

    // Request FIFO storage write
    always_ff @(posedge clk_i) begin
        if (req_push) req_mem[req_wptr_reg] <= {core_add_i, core_wen_i, core_wdata_i, core_be_i};
    end

    // Response FIFO storage write
    always_ff @(posedge clk_i) begin
        if (rsp_push) rsp_mem[rsp_wptr_reg] <= tcdm_rdata_i;
    end

    // Request FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_wptr_reg  <= '0;
            req_rptr_reg  <= '0;
            req_count_reg <= '0;
        end else begin
            if (req_push)
                req_wptr_reg <= (req_wptr_reg == ReqPtrW'(ReqDepth - 1)) ? '0 : req_wptr_reg + ReqPtrW'(1);
            if (grant)
                req_rptr_reg <= (req_rptr_reg == ReqPtrW'(ReqDepth - 1)) ? '0 : req_rptr_reg + ReqPtrW'(1);
            case ({req_push, grant})
                2'b10:   req_count_reg <= req_count_reg + ReqCntW'(1);
                2'b01:   req_count_reg <= req_count_reg - ReqCntW'(1);
                default: req_count_reg <= req_count_reg;
            endcase
        end
    end

    // Response FIFO pointers, occupancy, in-flight credits and sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_wptr_reg  <= '0;
            rsp_rptr_reg  <= '0;
            rsp_count_reg <= '0;
            inflight_reg  <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (rsp_push)
                rsp_wptr_reg <= (rsp_wptr_reg == RspPtrW'(RespDepth - 1)) ? '0 : rsp_wptr_reg + RspPtrW'(1);
            if (rsp_pop)
                rsp_rptr_reg <= (rsp_rptr_reg == RspPtrW'(RespDepth - 1)) ? '0 : rsp_rptr_reg + RspPtrW'(1);
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_count_reg <= rsp_count_reg + CntW'(1);
                2'b01:   rsp_count_reg <= rsp_count_reg - CntW'(1);
                default: rsp_count_reg <= rsp_count_reg;
            endcase
            case ({grant && need, rsp_push})
                2'b10:   inflight_reg <= inflight_reg + CntW'(1);
                2'b01:   inflight_reg <= inflight_reg - CntW'(1);
                default: inflight_reg <= inflight_reg;
            endcase
            if (spurious) err_reg <= 1'b1;
        end
    end

`ifdef TCDM_SHIM_PERF_EN
    logic [31:0] perf_stall_reg;

    // Count cycles where a request waits for grant, saturating at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_stall_reg <= '0;
        end else if (tcdm_req_o && !tcdm_gnt_i && (perf_stall_reg != 32'hFFFF_FFFF)) begin
            perf_stall_reg <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_stall_o = perf_stall_reg;
`else
    assign perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_tcdm_initiator_shim.sv
// Testbench for tcdm_initiator_shim: directed scenarios plus a random phase, all
// checked every cycle against a queue-based transaction model of the shim.
module tb_tcdm_initiator_shim;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int RQD = 2;
    localparam int RSD = 4;
    localparam int WRO = 1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          core_req_valid_i, core_req_ready_o;
    logic [AW-1:0] core_add_i;
    logic          core_wen_i;
    logic [DW-1:0] core_wdata_i;
    logic [BW-1:0] core_be_i;
    logic          core_rsp_valid_o, core_rsp_ready_i;
    logic [DW-1:0] core_rsp_rdata_o;
    logic          tcdm_req_o, tcdm_gnt_i;
    logic [AW-1:0] tcdm_add_o;
    logic          tcdm_wen_o;
    logic [DW-1:0] tcdm_wdata_o;
    logic [BW-1:0] tcdm_be_o;
    logic          tcdm_vld_i;
    logic [DW-1:0] tcdm_rdata_i;
    logic          err_o;
    logic [31:0]   perf_stall_o;

    tcdm_initiator_shim #(
        .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW),
        .ReqDepth(RQD), .RespDepth(RSD), .WriteRespOn(WRO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
        .core_add_i(core_add_i), .core_wen_i(core_wen_i),
        .core_wdata_i(core_wdata_i), .core_be_i(core_be_i),
        .core_rsp_valid_o(core_rsp_valid_o), .core_rsp_ready_i(core_rsp_ready_i),
        .core_rsp_rdata_o(core_rsp_rdata_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i),
        .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
        .tcdm_wdata_o(tcdm_wdata_o), .tcdm_be_o(tcdm_be_o),
        .tcdm_vld_i(tcdm_vld_i), .tcdm_rdata_i(tcdm_rdata_i),
        .err_o(err_o), .perf_stall_o(perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AW-1:0] add;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } req_t;

    // Transaction-level model of the shim
    req_t          m_req_q[$];
    logic [DW-1:0] m_rsp_q[$];
    int            m_inflight;
    bit            m_err;
    longint        m_stall;
    int            m_grants, m_pushes, m_rsp_pops;
    bit            auto_resp;

    int total = 0;
    int passed = 0;
    int failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_need();
        return (m_req_q.size() > 0) && (!m_req_q[0].wen || (WRO != 0));
    endfunction

    function automatic bit m_tcdm_req();
        return (m_req_q.size() > 0) &&
               ((m_inflight + m_rsp_q.size() + int'(m_need())) <= RSD);
    endfunction

    task automatic check_outputs(input string ctx);
        logic [31:0] exp_perf;
`ifdef TCDM_SHIM_PERF_EN
        exp_perf = m_stall[31:0];
`else
        exp_perf = 32'd0;
`endif
        check({ctx, ".ready"}, core_req_ready_o, m_req_q.size() < RQD);
        check({ctx, ".req"}, tcdm_req_o, m_tcdm_req());
        check({ctx, ".add"}, tcdm_add_o, m_req_q.size() > 0 ? m_req_q[0].add : 32'd0);
        check({ctx, ".wen"}, tcdm_wen_o, m_req_q.size() > 0 ? m_req_q[0].wen : 1'b0);
        check({ctx, ".wdata"}, tcdm_wdata_o, m_req_q.size() > 0 ? m_req_q[0].wdata : 32'd0);
        check({ctx, ".be"}, tcdm_be_o, m_req_q.size() > 0 ? m_req_q[0].be : 4'd0);
        check({ctx, ".rsp_valid"}, core_rsp_valid_o, m_rsp_q.size() > 0);
        check({ctx, ".rsp_rdata"}, core_rsp_rdata_o, m_rsp_q.size() > 0 ? m_rsp_q[0] : 32'd0);
        check({ctx, ".err"}, err_o, m_err);
        check({ctx, ".perf"}, perf_stall_o, exp_perf);
    endtask

    // One clock: check outputs, apply the current inputs to the model at the edge.
    task automatic cycle(input string ctx);
        bit fire, fire_need, accept, rpop, stall;
        req_t r;
        check_outputs(ctx);
        fire      = m_tcdm_req() && tcdm_gnt_i;
        fire_need = fire && m_need();
        accept    = core_req_valid_i && (m_req_q.size() < RQD);
        rpop      = (m_rsp_q.size() > 0) && core_rsp_ready_i;
        stall     = m_tcdm_req() && !tcdm_gnt_i;
        r.add = core_add_i; r.wen = core_wen_i; r.wdata = core_wdata_i; r.be = core_be_i;
        @(posedge clk_i);
        if (rpop) begin
            $display("%s: core response data=%h", ctx, m_rsp_q[0]);
            void'(m_rsp_q.pop_front());
            m_rsp_pops++;
        end
        if (tcdm_vld_i) begin
            if (m_inflight == 0) m_err = 1'b1;
            else begin
                m_inflight--;
                m_rsp_q.push_back(tcdm_rdata_i);
            end
        end
        if (fire) begin
            void'(m_req_q.pop_front());
            m_inflight += int'(fire_need);
            m_grants++;
        end
        if (accept) begin
            m_req_q.push_back(r);
            m_pushes++;
        end
        if (stall && m_stall < 64'hFFFF_FFFF) m_stall++;
        @(negedge clk_i);
        if (auto_resp) begin
            tcdm_vld_i   = fire_need;
            tcdm_rdata_i = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        core_req_valid_i = 0; core_add_i = 0; core_wen_i = 0; core_wdata_i = 0; core_be_i = 0;
        core_rsp_ready_i = 0; tcdm_gnt_i = 0; tcdm_vld_i = 0; tcdm_rdata_i = 0;
        auto_resp = 0;
        #1;
        m_req_q.delete(); m_rsp_q.delete();
        m_inflight = 0; m_err = 0; m_stall = 0;
        m_grants = 0; m_pushes = 0; m_rsp_pops = 0;
        check_outputs("reset");
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        @(negedge clk_i);

        // Single load with immediate grant and a response one cycle later
        do_reset();
        tcdm_gnt_i = 1; core_req_valid_i = 1; core_add_i = 32'h40; core_be_i = 4'hF;
        check("load.req_before", tcdm_req_o, 1'b0);
        cycle("load");
        core_req_valid_i = 0;
        check("load.req_rise", tcdm_req_o, 1'b1);
        check("load.add", tcdm_add_o, 32'h40);
        cycle("load");
        tcdm_vld_i = 1; tcdm_rdata_i = 32'hCAFE_F00D;
        check("load.rsp_before", core_rsp_valid_o, 1'b0);
        cycle("load");
        tcdm_vld_i = 0;
        check("load.rsp_valid", core_rsp_valid_o, 1'b1);
        check("load.rsp_data", core_rsp_rdata_o, 32'hCAFE_F00D);
        core_rsp_ready_i = 1;
        cycle("load");
        core_rsp_ready_i = 0;
        check("load.rsp_gone", core_rsp_valid_o, 1'b0);

        // Conflict: five stall cycles with the head held steady
        do_reset();
        auto_resp = 1; core_rsp_ready_i = 1;
        core_req_valid_i = 1; core_wen_i = 1; core_add_i = 32'h1234;
        core_wdata_i = 32'hDEAD_BEEF; core_be_i = 4'h5;
        cycle("conflict");
        core_req_valid_i = 0;
        for (int i = 0; i < 5; i++) begin
            check("conflict.req", tcdm_req_o, 1'b1);
            check("conflict.add", tcdm_add_o, 32'h1234);
            check("conflict.wdata", tcdm_wdata_o, 32'hDEAD_BEEF);
            check("conflict.be", tcdm_be_o, 4'h5);
            cycle("conflict");
        end
`ifdef TCDM_SHIM_PERF_EN
        check("conflict.perf", perf_stall_o, 32'd5);
`else
        check("conflict.perf", perf_stall_o, 32'd0);
`endif
        tcdm_gnt_i = 1;
        cycle("conflict");
        tcdm_gnt_i = 0;
        check("conflict.popped", tcdm_req_o, 1'b0);
        for (int i = 0; i < 3; i++) cycle("conflict");

        // Credit limit: six loads, response FIFO never drained
        do_reset();
        auto_resp = 1; tcdm_gnt_i = 1;
        for (int i = 0; i < 20; i++) begin
            core_req_valid_i = (m_pushes < 6);
            core_add_i = $urandom & 32'hFFFF_FFFC; core_wen_i = 0; core_be_i = 4'hF;
            cycle("credit");
        end
        core_req_valid_i = 0;
        check("credit.grants4", m_grants, 4);
        check("credit.req_low", tcdm_req_o, 1'b0);
        core_rsp_ready_i = 1;
        cycle("credit");
        core_rsp_ready_i = 0;
        for (int i = 0; i < 10; i++) cycle("credit");
        check("credit.grants5", m_grants, 5);

        // Stores: each one is acknowledged with a response
        do_reset();
        auto_resp = 1; tcdm_gnt_i = 1; core_rsp_ready_i = 1;
        for (int i = 0; i < 12; i++) begin
            core_req_valid_i = (m_pushes < 3);
            core_wen_i = 1; core_add_i = 32'h100 + 4 * i; core_wdata_i = $urandom; core_be_i = 4'h3;
            cycle("store");
        end
        core_req_valid_i = 0;
        check("store.grants", m_grants, 3);
        check("store.responses", m_rsp_pops, 3);

        // Full request FIFO with no grants, then one grant reopens it
        do_reset();
        core_req_valid_i = 1; core_wen_i = 0; core_add_i = 32'h80; core_be_i = 4'hF;
        check("full.ready0", core_req_ready_o, 1'b1);
        cycle("full");
        check("full.ready1", core_req_ready_o, 1'b1);
        cycle("full");
        check("full.ready2", core_req_ready_o, 1'b0);
        cycle("full");
        tcdm_gnt_i = 1;
        cycle("full");
        tcdm_gnt_i = 0; core_req_valid_i = 0;
        check("full.reopen", core_req_ready_o, 1'b1);
        cycle("full");

        // Spurious vld sets a sticky error that only reset clears
        do_reset();
        tcdm_vld_i = 1; tcdm_rdata_i = 32'h1111_2222;
        cycle("spur");
        tcdm_vld_i = 0;
        check("spur.err", err_o, 1'b1);
        check("spur.no_rsp", core_rsp_valid_o, 1'b0);
        cycle("spur");
        check("spur.sticky", err_o, 1'b1);
        do_reset();
        check("spur.cleared", err_o, 1'b0);

        // Reset with a load in flight, then the late vld arrives
        core_req_valid_i = 1; core_wen_i = 0; core_add_i = 32'h200; tcdm_gnt_i = 1;
        cycle("midrst");
        core_req_valid_i = 0;
        cycle("midrst");
        do_reset();
        tcdm_vld_i = 1;
        cycle("midrst");
        tcdm_vld_i = 0;
        check("midrst.err", err_o, 1'b1);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            core_req_valid_i = $urandom_range(0, 1);
            core_add_i       = $urandom;
            core_wen_i       = $urandom_range(0, 1);
            core_wdata_i     = $urandom;
            core_be_i        = 4'($urandom);
            core_rsp_ready_i = ($urandom_range(0, 3) < (i < 200 ? 1 : 3));
            tcdm_gnt_i       = ($urandom_range(0, 2) != 0);
            tcdm_vld_i       = (m_inflight > 0) && ($urandom_range(0, 1) == 1);
            tcdm_rdata_i     = $urandom;
            cycle("rand");
        end
        check_outputs("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
